// File: rtl/ram_burst_reader.sv
// ram_burst_reader: drains the capture RAM over a valid/ready stream once
// capture completes. Words 0..max_ram_address-2 go out in bursts of
// burst_index beats, each burst gated by a burst_req/burst_grant handshake.
// Optional feature macro: RAM_READER_CHECKSUM_EN appends a one-beat burst
// carrying the XOR of every transmitted word.
module ram_burst_reader #(
  parameter int address_width   = 14,
  parameter int max_ram_address = 16384,
  parameter int burst_index     = 8,
  parameter int data_width      = 32
) (
  input  logic                     variable_clk_2,
  input  logic                     reset,
  input  logic                     start_signal,
  input  logic                     capture_enable,
  output logic                     ram_rd_en,
  output logic [address_width-1:0] ram_rd_addr,
  input  logic [data_width-1:0]    ram_rd_data,
  output logic                     burst_req,
  input  logic                     burst_grant,
  output logic [data_width-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic                     transfer_done,
  output logic                     busy
);

  localparam int TOTAL = max_ram_address - 1;
  localparam int CMAX  = (TOTAL > burst_index) ? TOTAL : burst_index;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int BW    = $clog2(burst_index + 1);

  localparam logic [CW-1:0]            TOTAL_C   = CW'(TOTAL);
  localparam logic [CW-1:0]            BURST_C   = CW'(burst_index);
  localparam logic [BW-1:0]            BURST_B   = BW'(burst_index);
  localparam logic [BW-1:0]            ONE_B     = BW'(1);
  localparam logic [address_width-1:0] LAST_ADDR = address_width'(max_ram_address - 2);
  localparam logic [address_width-1:0] ONE_A     = address_width'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic                     cap_q;
  logic [CW-1:0]            rem_q, rem_d;         // words not yet assigned to a burst
  logic [BW-1:0]            rd_left_q, rd_left_d; // reads still to issue this burst
  logic [BW-1:0]            hs_left_q, hs_left_d; // beats still to hand off this burst
  logic [BW-1:0]            beats;
  logic [address_width-1:0] addr_q, addr_d;

  // Two-entry output buffer plus one outstanding RAM read
  logic                     inflight_q;
  logic [data_width-1:0]    buf_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               cnt_q, cnt_d;

  logic                     trigger;
  logic                     rd_issue;
  logic                     hs, hs_data;
  logic                     push, pop;
  logic                     data_vld;
  logic [data_width-1:0]    head_data;

`ifdef RAM_READER_CHECKSUM_EN
  logic                     cks_phase_q, cks_phase_d;
  logic [data_width-1:0]    cks_q, cks_d;
`endif

  assign trigger     = cap_q && !capture_enable && !start_signal;
  assign ram_rd_en   = rd_issue;
  assign ram_rd_addr = addr_q;

  // Buffer head; when the buffer is empty the word returning from RAM this
  // cycle is presented directly, and is captured next cycle if not taken, so
  // the presented value does not change while stalled.
  assign data_vld  = (cnt_q != 2'd0) || inflight_q;
  assign head_data = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : ram_rd_data;

`ifdef RAM_READER_CHECKSUM_EN
  assign hs_data = hs && !cks_phase_q;
`else
  assign hs_data = hs;
`endif

  assign push  = inflight_q && !((cnt_q == 2'd0) && hs_data);
  assign pop   = hs_data && (cnt_q != 2'd0);
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  // Next-state and output decode for the burst sequencer
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    rd_left_d     = rd_left_q;
    hs_left_d     = hs_left_q;
    addr_d        = addr_q;
    beats         = '0;
    rd_issue      = 1'b0;
    hs            = 1'b0;
    burst_req     = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_last       = 1'b0;
    transfer_done = 1'b0;
    busy          = (state_q != S_IDLE);
`ifdef RAM_READER_CHECKSUM_EN
    cks_phase_d   = cks_phase_q;
    cks_d         = cks_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          rem_d   = TOTAL_C;
          addr_d  = '0;
          state_d = S_WAIT_GRANT;
`ifdef RAM_READER_CHECKSUM_EN
          cks_phase_d = 1'b0;
          cks_d       = '0;
`endif
        end
      end

      S_WAIT_GRANT: begin
        burst_req = 1'b1;
        if (burst_grant) begin
          beats = (rem_q >= BURST_C) ? BURST_B : BW'(rem_q);
`ifdef RAM_READER_CHECKSUM_EN
          if (cks_phase_q) begin
            rd_left_d = '0;
            hs_left_d = ONE_B;
          end else
`endif
          begin
            rd_left_d = beats;
            hs_left_d = beats;
            rem_d     = rem_q - CW'(beats);
          end
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
`ifdef RAM_READER_CHECKSUM_EN
        if (cks_phase_q) begin
          tx_valid = 1'b1;
          tx_data  = cks_q;
          tx_last  = 1'b1;
        end else
`endif
        begin
          // Keep buffered + outstanding words at or below the buffer depth
          rd_issue = (rd_left_q != '0) &&
                     (({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'd2);
          tx_valid = data_vld;
          tx_data  = data_vld ? head_data : '0;
          tx_last  = data_vld && (hs_left_q == ONE_B);
        end

        hs = tx_valid && tx_ready;

        if (rd_issue) begin
          rd_left_d = rd_left_q - ONE_B;
          // Hold at the last valid word rather than stepping past the RAM
          if (addr_q != LAST_ADDR) addr_d = addr_q + ONE_A;
        end

`ifdef RAM_READER_CHECKSUM_EN
        if (hs_data) cks_d = cks_q ^ tx_data;
`endif

        if (hs) begin
          hs_left_d = hs_left_q - ONE_B;
          if (hs_left_q == ONE_B) begin
            if (rem_q != '0) state_d = S_WAIT_GRANT;
`ifdef RAM_READER_CHECKSUM_EN
            else if (!cks_phase_q) begin
              state_d     = S_WAIT_GRANT;
              cks_phase_d = 1'b1;
            end
`endif
            else state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        transfer_done = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, counters and the capture_enable edge detector
  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cap_q     <= 1'b0;
      rem_q     <= '0;
      rd_left_q <= '0;
      hs_left_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= capture_enable;
      rem_q     <= rem_d;
      rd_left_q <= rd_left_d;
      hs_left_q <= hs_left_d;
      addr_q    <= addr_d;
    end
  end

  // Buffer control; reset drops any outstanding read and empties the buffer
  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      inflight_q <= rd_issue;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage; contents are only observed through the occupancy count
  always_ff @(posedge variable_clk_2) begin
    if (push) buf_q[wr_ptr_q] <= ram_rd_data;
  end

`ifdef RAM_READER_CHECKSUM_EN
  // Running XOR of transmitted words and the checksum-burst flag
  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      cks_phase_q <= 1'b0;
      cks_q       <= '0;
    end else begin
      cks_phase_q <= cks_phase_d;
      cks_q       <= cks_d;
    end
  end
`endif

endmodule
